mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
Shares the single-ported 4K x 16 main memory between two requesters. Master 0 is the control unit's fetch/execute path. Master 1 is the I/O / DMA path (keyboard buffer and display fill). The block arbitrates round-robin with an atomic-lock option, so ISZ-style read-modify-write sequences are not interleaved. It drives the memory strobes and returns read data per master.

Parameters:
ADDR_W, 12, memory address width
DATA_W, 16, memory word width
RD_LAT, 1, cycles from the mem_read cycle until mem_rdata is valid (range 1..4)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
m0_req  in  1  master 0 access request; held with attributes until m0_gnt
m0_we  in  1  1 = write, 0 = read
m0_lock  in  1  keep ownership after this access
m0_addr  in  ADDR_W  access address
m0_wdata  in  DATA_W  write data
m0_gnt  out  1  one-cycle pulse: access issued to memory
m0_rvalid  out  1  one-cycle pulse: rdata holds master 0 read result
m1_req, m1_we, m1_lock, m1_addr, m1_wdata, m1_gnt, m1_rvalid  as master 0, for master 1
rdata  out  DATA_W  registered read data, shared; qualified by mX_rvalid
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (any time, asynchronous):
  - All outputs go to 0; state = IDLE; locked = 0; last_gnt = 1, so master 0 wins the first tie.
  - An in-flight read is abandoned; no rvalid is produced.
- All outputs are registered.
- States:
  - IDLE: arbitrate on each edge.
  - ISSUE: exactly 1 cycle.
  - RDWAIT: RD_LAT cycles, reads only.
- IDLE, arbitration at an edge with any req high:
  - If locked, only the lock owner is eligible; the other master's req is ignored.
  - If not locked and exactly one req is high, that master wins.
  - If not locked and both are high, the master != last_gnt wins.
  - The winner's attributes are registered. The next cycle is ISSUE, with mX_gnt=1, mem_addr=addr, and mem_write=we / mem_read=~we (mem_wdata=wdata when we=1).
  - last_gnt is set to the winner; locked is set to the winner's lock bit.
- ISSUE: strobes and gnt are high for this cycle only.
  - Write: return to IDLE.
  - Read: go to RDWAIT.
- RDWAIT:
  - mem_read is low; count RD_LAT cycles.
  - At the edge ending the last count cycle, capture mem_rdata into rdata.
  - Then state = IDLE with mX_rvalid=1 for 1 cycle.
  - Arbitration in that IDLE cycle proceeds normally.
- Latency from req sampled at edge E0 (IDLE):
  - gnt/strobe in the cycle after E0.
  - Read rvalid in cycle 2+RD_LAT after E0.
- Throughput:
  - Writes: one per 2 cycles.
  - Reads: one per 2+RD_LAT cycles.
  - Two-master alternation is guaranteed when both request continuously and neither locks.
- Lock: ownership is released only when the owner's next granted access has lock=0. While the owner has req=0, the arbiter idles (no timeout).
- Requester contract:
  - req and attributes are stable from assertion through the gnt cycle.
  - req is dropped or re-presented for a new access the cycle after gnt.
  - A req dropped before gnt is legal and results in no access.
- rdata holds its value until the next read capture; it is not cleared on writes.
- mem_addr and mem_wdata hold their last values when idle; the strobes are 0.
- mem_read and mem_write are never high together, and never high outside ISSUE.
- Exactly one gnt pulse per memory access.

Decomposition:
- Shared package mano_bus_pkg: ADDR_W/DATA_W defaults, state enum (ST_IDLE, ST_ISSUE, ST_RDWAIT), master index constants M_CPU=0 and M_IO=1.
- One sub-module, rr_pick2: combinational 2-way round-robin/lock winner select (inputs: reqs, last_gnt, locked, lock_owner; outputs: valid, winner).
- Counter, FSM, and registers stay in the top module.

Test Plan:
- m0 reads addr 0x010 (memory word 0x7A5C), RD_LAT=1 → m0_gnt in cycle 1 with mem_read=1, mem_addr=0x010; m0_rvalid=1 and rdata=0x7A5C in cycle 3; no m1 pulses.
- m0 and m1 writes requested in the same cycle after reset → m0 granted first, m1 next (mem_write cycles 1 and 3); then both re-request and m0 wins again (alternation).
- m0 read 0x020 with lock=1, then write 0x020 with lock=0, while m1 requests continuously → m1_gnt only after m0's write ISSUE; m1 is never granted between the two.
- RD_LAT=3, m1 read → m1_rvalid in cycle 5 after sampling; busy high cycles 1–4; no strobes in cycles 2–4.
- Reset asserted during RDWAIT → all outputs 0 immediately; no rvalid after release; the first post-reset tie goes to m0.
- m1 req raised then dropped before gnt while m0 holds the bus → no m1 access; mem_write/mem_read are never both high (assertion across the run).

Source files
------------

// File: rtl/mano_bus_pkg.sv
// Shared definitions for the main-memory bus: default widths, arbiter states
// and master indices.
package mano_bus_pkg;

    localparam int BUS_ADDR_W = 12;
    localparam int BUS_DATA_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RDWAIT = 2'd2
    } state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_IO  = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way winner select: round-robin on ties, restricted to the lock owner
// while a locked sequence is in progress.
module rr_pick2
    import mano_bus_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last_gnt,
    input  logic       locked,
    input  logic       lock_owner,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = 1'b0;
        winner = M_CPU;
        if (locked) begin
            // The non-owner is invisible until the owner releases the lock.
            valid  = reqs[lock_owner];
            winner = lock_owner;
        end else begin
            unique case (reqs)
                2'b01:   begin valid = 1'b1; winner = M_CPU;     end
                2'b10:   begin valid = 1'b1; winner = M_IO;      end
                2'b11:   begin valid = 1'b1; winner = ~last_gnt; end
                default: begin valid = 1'b0; winner = M_CPU;     end
            endcase
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported main memory between the CPU path (master 0)
// and the I/O/DMA path (master 1), with an atomic lock for read-modify-write.
module mem_port_arbiter
    import mano_bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic              m0_lock,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic              m1_lock,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

    state_t              state_reg;
    logic [1:0]          cnt_reg;
    logic                owner_reg;
    logic                last_gnt_reg;
    logic                locked_reg;
    logic [1:0]          gnt_reg;
    logic [1:0]          rvalid_reg;
    logic [DATA_W-1:0]   rdata_reg;
    logic                mem_read_reg;
    logic                mem_write_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic                busy_reg;

    logic                pick_valid;
    logic                pick_winner;
    logic                sel_we;
    logic                sel_lock;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    rr_pick2 u_pick (
        .reqs       ({m1_req, m0_req}),
        .last_gnt   (last_gnt_reg),
        .locked     (locked_reg),
        .lock_owner (last_gnt_reg),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign sel_we    = pick_winner ? m1_we    : m0_we;
    assign sel_lock  = pick_winner ? m1_lock  : m0_lock;
    assign sel_addr  = pick_winner ? m1_addr  : m0_addr;
    assign sel_wdata = pick_winner ? m1_wdata : m0_wdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            owner_reg     <= M_CPU;
            last_gnt_reg  <= M_IO;
            locked_reg    <= 1'b0;
            gnt_reg       <= '0;
            rvalid_reg    <= '0;
            rdata_reg     <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            busy_reg      <= 1'b0;
        end else begin
            gnt_reg       <= '0;
            rvalid_reg    <= '0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (pick_valid) begin
                        state_reg     <= ST_ISSUE;
                        busy_reg      <= 1'b1;
                        owner_reg     <= pick_winner;
                        last_gnt_reg  <= pick_winner;
                        locked_reg    <= sel_lock;
                        gnt_reg       <= pick_winner ? 2'b10 : 2'b01;
                        mem_addr_reg  <= sel_addr;
                        mem_write_reg <= sel_we;
                        mem_read_reg  <= ~sel_we;
                        if (sel_we) begin
                            mem_wdata_reg <= sel_wdata;
                        end
                    end
                end
                ST_ISSUE: begin
                    // mem_write_reg still reflects the access being issued.
                    if (mem_write_reg) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        state_reg <= ST_RDWAIT;
                        cnt_reg   <= CNT_INIT;
                    end
                end
                ST_RDWAIT: begin
                    if (cnt_reg == 2'd0) begin
                        state_reg  <= ST_IDLE;
                        busy_reg   <= 1'b0;
                        rdata_reg  <= mem_rdata;
                        rvalid_reg <= owner_reg ? 2'b10 : 2'b01;
                    end else begin
                        cnt_reg <= cnt_reg - 2'd1;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign m0_gnt    = gnt_reg[M_CPU];
    assign m1_gnt    = gnt_reg[M_IO];
    assign m0_rvalid = rvalid_reg[M_CPU];
    assign m1_rvalid = rvalid_reg[M_IO];
    assign rdata     = rdata_reg;
    assign mem_read  = mem_read_reg;
    assign mem_write = mem_write_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign busy      = busy_reg;

endmodule
